tdp_ram_bwe: RTL and testbench
==============================

Name: tdp_ram_bwe

Overview:
Parametrised true dual-port synchronous RAM. Two independent read/write ports share one clock. Adds per-byte write enables, selectable read-during-write mode, an optional output register, and cross-port collision flagging. A hardware scrub FSM loads INIT_VAL into every location after reset or on request. It is the general-purpose on-chip buffer for wide datapaths.

Parameters:
WIDTH, 32, data width in bits; must be a multiple of BYTE_W
LOCATION, 64, number of words; need not be a power of two
BYTE_W, 8, bits per write-enable lane; NB = WIDTH/BYTE_W lanes
RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (merged new data)
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
INIT_VAL, 0, word value written to every location by the scrub FSM

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  one-cycle pulse; starts a scrub when the FSM is IDLE
busy  out  1  high while scrubbing; all port requests are ignored while high
en_a  in  1  port A access enable
we_a  in  NB  port A byte write enables; all zero = pure read
addr_a  in  $clog2(LOCATION)  port A word address
din_a  in  WIDTH  port A write data
dout_a  out  WIDTH  port A read data
vld_a  out  1  port A read data valid
en_b, we_b, addr_b, din_b, dout_b, vld_b  same widths as port A  port B equivalents
coll  out  1  address collision flag, registered

Behaviour:
- Reset: asynchronous on rst_n low. dout_a/b=0, vld_a/b=0, coll=0, busy=1, FSM=CLEAR, scrub counter=0. Memory array is not reset.
- FSM states: CLEAR and IDLE.
  - CLEAR: writes INIT_VAL to mem[cnt], increments cnt each cycle. After cnt==LOCATION-1 is written -> IDLE, busy=0. Scrub takes exactly LOCATION cycles after rst_n rises.
  - IDLE: clr=1 -> CLEAR, cnt=0, busy=1 on the next edge.
  - clr in CLEAR is ignored. rst_n low mid-scrub restarts the scrub from address 0.
- Access acceptance: a port accepts an access when en=1 and busy=0. The accepted access is a write for each lane with we[i]=1 and always a read. Unaccepted cycles leave the memory, dout and vld unchanged, except that vld drops to 0.
- Write: only enabled lanes are updated, i.e. mem[addr][i*BYTE_W +: BYTE_W] <= din lane i. Lanes with we[i]=0 keep their old value.
- Read data on an accepted access, same port:
  - RDW_MODE=0: pre-edge word.
  - RDW_MODE=1: old word with that port's enabled lanes replaced by din.
- Latency: with OUT_REG=0, dout and vld update on the edge after acceptance. With OUT_REG=1, add one stage, so vld is 2 cycles after acceptance. In both cases dout holds its last value when vld=0. The pipeline is fully streaming, one access per port per cycle.
- Cross-port reads always return the pre-edge contents, regardless of RDW_MODE.
- Write-write, same address, same lane: port A wins. Non-overlapping lanes from both ports are all written.
- Collision: both ports accepted, addr_a==addr_b, and we_a|we_b nonzero -> coll=1 on the next edge, otherwise 0. Timing of coll is independent of OUT_REG.
- Out-of-range address (>= LOCATION): write dropped. Read accepted with vld=1, dout=0. No collision is flagged unless the addresses are equal and in range.

Test Plan:
- Reset/scrub: WIDTH=32, LOCATION=16, INIT_VAL=32'hA5A5A5A5. Release rst_n -> busy high for exactly 16 cycles. Then read all 16 addresses on A and B -> every word is A5A5A5A5.
- Byte write: port A writes addr 3 with we_a=4'b0101, din_a=32'h11223344 over A5A5A5A5. Read addr 3 on B -> 32'hA522A544, vld_b 1 cycle after the read (OUT_REG=0), 2 cycles after (OUT_REG=1).
- RDW mode: addr 5 holds 0. Port A writes 32'hDEADBEEF with we=4'hF. RDW_MODE=0 -> dout_a=0; RDW_MODE=1 -> dout_a=DEADBEEF. Same cycle, B reads addr 5 -> dout_b=0 in both modes.
- Collision: A writes addr 7 with we=4'b0011, din=32'h0000AAAA. B writes addr 7 with we=4'b0110, din=32'h00BBBB00. Next cycle coll=1, and addr 7 holds {A5,BB,AA,AA} = 32'hA5BBAAAA.
- Mid-scrub: pulse clr in IDLE; 5 cycles later assert en_a write -> write ignored, vld_a=0. Pull rst_n low at cycle 8 -> scrub restarts, busy for a fresh 16 cycles.
- Out of range: LOCATION=12. Write addr 13, then read addr 13 -> vld=1, dout=0. Addresses 0-11 are unchanged.

Source files
------------

// File: rtl/tdp_ram_bwe.sv
// rtl/tdp_ram_bwe.sv - true dual-port RAM with byte write enables, RDW mode, output register and scrub FSM
module tdp_ram_bwe #(
    parameter int                 WIDTH    = 32,
    parameter int                 LOCATION = 64,
    parameter int                 BYTE_W   = 8,
    parameter int                 RDW_MODE = 0,
    parameter int                 OUT_REG  = 0,
    parameter logic [WIDTH-1:0]   INIT_VAL = '0
) (
    input  logic                                    clk_i,
    input  logic                                    rst_n_i,
    input  logic                                    clr_i,
    output logic                                    busy_o,
    input  logic                                    en_a_i,
    input  logic [WIDTH/BYTE_W-1:0]                 we_a_i,
    input  logic [((LOCATION > 1) ? $clog2(LOCATION) : 1)-1:0] addr_a_i,
    input  logic [WIDTH-1:0]                        din_a_i,
    output logic [WIDTH-1:0]                        dout_a_o,
    output logic                                    vld_a_o,
    input  logic                                    en_b_i,
    input  logic [WIDTH/BYTE_W-1:0]                 we_b_i,
    input  logic [((LOCATION > 1) ? $clog2(LOCATION) : 1)-1:0] addr_b_i,
    input  logic [WIDTH-1:0]                        din_b_i,
    output logic [WIDTH-1:0]                        dout_b_o,
    output logic                                    vld_b_o,
    output logic                                    coll_o
);
    localparam int NB = WIDTH / BYTE_W;
    localparam int AW = (LOCATION > 1) ? $clog2(LOCATION) : 1;
    localparam logic [AW:0]   LOC_W = (AW+1)'(LOCATION);
    localparam logic [AW-1:0] LAST  = AW'(LOCATION - 1);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] mem [LOCATION];

    logic             acc_a, acc_b, inr_a, inr_b;
    logic [WIDTH-1:0] rd_a, rd_b;
    logic [WIDTH-1:0] dout1_a_q, dout1_b_q;
    logic             vld1_a_q, vld1_b_q, coll_q;

    assign busy_o = (state_q == S_CLEAR);
    assign acc_a  = en_a_i & ~busy_o;
    assign acc_b  = en_b_i & ~busy_o;
    assign inr_a  = {1'b0, addr_a_i} < LOC_W;
    assign inr_b  = {1'b0, addr_b_i} < LOC_W;
    assign coll_o = coll_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_IDLE: begin
                if (clr_i) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Port B is written first so port A's lane wins on a same-lane clash.
    always_ff @(posedge clk_i) begin
        if (busy_o) begin
            mem[cnt_q] <= INIT_VAL;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (acc_b && inr_b && we_b_i[i])
                    mem[addr_b_i][i*BYTE_W +: BYTE_W] <= din_b_i[i*BYTE_W +: BYTE_W];
                if (acc_a && inr_a && we_a_i[i])
                    mem[addr_a_i][i*BYTE_W +: BYTE_W] <= din_a_i[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Write-first merges only the reading port's own lanes; the other port is never visible.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (inr_a) rd_a = mem[addr_a_i];
        if (inr_b) rd_b = mem[addr_b_i];
        if (RDW_MODE != 0) begin
            for (int i = 0; i < NB; i++) begin
                if (inr_a && we_a_i[i]) rd_a[i*BYTE_W +: BYTE_W] = din_a_i[i*BYTE_W +: BYTE_W];
                if (inr_b && we_b_i[i]) rd_b[i*BYTE_W +: BYTE_W] = din_b_i[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dout1_a_q <= '0;
            dout1_b_q <= '0;
            vld1_a_q  <= 1'b0;
            vld1_b_q  <= 1'b0;
            coll_q    <= 1'b0;
        end else begin
            vld1_a_q <= acc_a;
            vld1_b_q <= acc_b;
            if (acc_a) dout1_a_q <= rd_a;
            if (acc_b) dout1_b_q <= rd_b;
            coll_q <= acc_a & acc_b & inr_a & (addr_a_i == addr_b_i) & (|(we_a_i | we_b_i));
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [WIDTH-1:0] dout2_a_q, dout2_b_q;
            logic             vld2_a_q, vld2_b_q;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    dout2_a_q <= '0;
                    dout2_b_q <= '0;
                    vld2_a_q  <= 1'b0;
                    vld2_b_q  <= 1'b0;
                end else begin
                    vld2_a_q <= vld1_a_q;
                    vld2_b_q <= vld1_b_q;
                    if (vld1_a_q) dout2_a_q <= dout1_a_q;
                    if (vld1_b_q) dout2_b_q <= dout1_b_q;
                end
            end

            assign dout_a_o = dout2_a_q;
            assign dout_b_o = dout2_b_q;
            assign vld_a_o  = vld2_a_q;
            assign vld_b_o  = vld2_b_q;
        end else begin : g_noreg
            assign dout_a_o = dout1_a_q;
            assign dout_b_o = dout1_b_q;
            assign vld_a_o  = vld1_a_q;
            assign vld_b_o  = vld1_b_q;
        end
    endgenerate
endmodule

// File: tb/tb_tdp_ram_bwe.sv
// tb/tb_tdp_ram_bwe.sv - self-checking bench for tdp_ram_bwe: two configurations against a reference model
module tb_tdp_ram_bwe;
    localparam logic [31:0] INIT = 32'hA5A5A5A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clr, en_a, en_b;
    logic [3:0]  we_a, we_b, addr_a, addr_b;
    logic [31:0] din_a, din_b;

    logic        busy_o [2];
    logic        vld_a_o [2];
    logic        vld_b_o [2];
    logic        coll_o [2];
    logic [31:0] dout_a_o [2];
    logic [31:0] dout_b_o [2];

    // Configuration 0: 16 words, read-first, latency 1. Configuration 1: 12 words, write-first, latency 2.
    tdp_ram_bwe #(.WIDTH(32), .LOCATION(16), .BYTE_W(8), .RDW_MODE(0), .OUT_REG(0), .INIT_VAL(INIT)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .busy_o(busy_o[0]),
        .en_a_i(en_a), .we_a_i(we_a), .addr_a_i(addr_a), .din_a_i(din_a), .dout_a_o(dout_a_o[0]), .vld_a_o(vld_a_o[0]),
        .en_b_i(en_b), .we_b_i(we_b), .addr_b_i(addr_b), .din_b_i(din_b), .dout_b_o(dout_b_o[0]), .vld_b_o(vld_b_o[0]),
        .coll_o(coll_o[0]));

    tdp_ram_bwe #(.WIDTH(32), .LOCATION(12), .BYTE_W(8), .RDW_MODE(1), .OUT_REG(1), .INIT_VAL(INIT)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .busy_o(busy_o[1]),
        .en_a_i(en_a), .we_a_i(we_a), .addr_a_i(addr_a), .din_a_i(din_a), .dout_a_o(dout_a_o[1]), .vld_a_o(vld_a_o[1]),
        .en_b_i(en_b), .we_b_i(we_b), .addr_b_i(addr_b), .din_b_i(din_b), .dout_b_o(dout_b_o[1]), .vld_b_o(vld_b_o[1]),
        .coll_o(coll_o[1]));

    int vectors = 0;
    int miscompares = 0;

    int          loc [2] = '{16, 12};
    bit          rdw [2] = '{1'b0, 1'b1};
    int          lat [2] = '{1, 2};
    logic [31:0] mem_m [2][16];
    int          scrub_left [2];
    logic        e_vld [2][2];
    logic [31:0] e_dout [2][2];
    logic        e_coll [2];
    logic        pv [2][2];
    logic [31:0] pd [2][2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        clr = 1'b0; en_a = 1'b0; en_b = 1'b0; we_a = '0; we_b = '0;
    endtask

    // Advance the model by one clock edge from the current inputs, then clock the DUTs and compare.
    task automatic step();
        logic        en_p [2];
        logic [3:0]  we_p [2];
        logic [3:0]  ad_p [2];
        logic [31:0] dn_p [2];
        logic [31:0] rv [2];
        bit          acc [2];
        bit          inr [2];
        bit          bsy;
        en_p = '{en_a, en_b}; we_p = '{we_a, we_b}; ad_p = '{addr_a, addr_b}; dn_p = '{din_a, din_b};
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                scrub_left[d] = loc[d];
                e_coll[d] = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    e_vld[d][p] = 1'b0; e_dout[d][p] = '0; pv[d][p] = 1'b0; pd[d][p] = '0;
                end
            end else begin
                bsy = scrub_left[d] > 0;
                for (int p = 0; p < 2; p++) begin
                    acc[p] = en_p[p] && !bsy;
                    inr[p] = int'(ad_p[p]) < loc[d];
                    rv[p] = '0;
                    if (inr[p]) begin
                        rv[p] = mem_m[d][ad_p[p]];
                        if (rdw[d])
                            for (int i = 0; i < 4; i++)
                                if (we_p[p][i]) rv[p][8*i +: 8] = dn_p[p][8*i +: 8];
                    end
                end
                e_coll[d] = acc[0] && acc[1] && inr[0] && (ad_p[0] == ad_p[1]) && ((we_p[0] | we_p[1]) != 0);
                for (int p = 1; p >= 0; p--)
                    if (acc[p] && inr[p])
                        for (int i = 0; i < 4; i++)
                            if (we_p[p][i]) mem_m[d][ad_p[p]][8*i +: 8] = dn_p[p][8*i +: 8];
                if (bsy) begin
                    mem_m[d][loc[d] - scrub_left[d]] = INIT;
                    scrub_left[d]--;
                end else if (clr) begin
                    scrub_left[d] = loc[d];
                end
                for (int p = 0; p < 2; p++) begin
                    if (lat[d] == 1) begin
                        e_vld[d][p] = acc[p];
                        if (acc[p]) e_dout[d][p] = rv[p];
                    end else begin
                        e_vld[d][p] = pv[d][p];
                        if (pv[d][p]) e_dout[d][p] = pd[d][p];
                        pv[d][p] = acc[p];
                        if (acc[p]) pd[d][p] = rv[p];
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d busy", d), 32'(busy_o[d]), 32'(scrub_left[d] > 0));
            chk($sformatf("dut%0d vld_a", d), 32'(vld_a_o[d]), 32'(e_vld[d][0]));
            chk($sformatf("dut%0d vld_b", d), 32'(vld_b_o[d]), 32'(e_vld[d][1]));
            chk($sformatf("dut%0d dout_a", d), dout_a_o[d], e_dout[d][0]);
            chk($sformatf("dut%0d dout_b", d), dout_b_o[d], e_dout[d][1]);
            chk($sformatf("dut%0d coll", d), 32'(coll_o[d]), 32'(e_coll[d]));
        end
    endtask

    // Steps until both configurations finish scrubbing and checks each busy span in cycles.
    task automatic scrub_span(input string tag);
        int f0, f1;
        f0 = 0; f1 = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (!busy_o[0] && f0 == 0) f0 = k;
            if (!busy_o[1] && f1 == 0) f1 = k;
            if (f0 != 0 && f1 != 0) break;
        end
        chk({tag, " busy span dut0"}, 32'(f0), 32'd16);
        chk({tag, " busy span dut1"}, 32'(f1), 32'd12);
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) begin
            en_a = 1'b1; en_b = 1'b1; we_a = '0; we_b = '0;
            addr_a = 4'(i); addr_b = 4'(15 - i);
            step();
        end
        idle(); step(); step();
    endtask

    initial begin
        rst_n = 1'b0; idle(); addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
        step(); step();
        rst_n = 1'b1;
        scrub_span("reset");
        read_all();

        en_a = 1'b1; we_a = 4'b0101; addr_a = 4'd3; din_a = 32'h11223344;
        step();
        idle(); en_b = 1'b1; addr_b = 4'd3;
        step();
        idle();
        chk("bytewr dut0 dout_b", dout_b_o[0], 32'hA522A544);
        chk("bytewr dut1 vld_b early", 32'(vld_b_o[1]), 32'd0);
        step();
        chk("bytewr dut1 dout_b", dout_b_o[1], 32'hA522A544);
        step();

        en_a = 1'b1; we_a = 4'hF; addr_a = 4'd5; din_a = 32'h0;
        step();
        en_a = 1'b1; we_a = 4'hF; addr_a = 4'd5; din_a = 32'hDEADBEEF; en_b = 1'b1; addr_b = 4'd5;
        step();
        idle();
        chk("rdw dut0 dout_a", dout_a_o[0], 32'h0);
        chk("rdw dut0 dout_b", dout_b_o[0], 32'h0);
        step();
        chk("rdw dut1 dout_a", dout_a_o[1], 32'hDEADBEEF);
        chk("rdw dut1 dout_b", dout_b_o[1], 32'h0);
        step();

        en_a = 1'b1; we_a = 4'b0011; addr_a = 4'd7; din_a = 32'h0000AAAA;
        en_b = 1'b1; we_b = 4'b0110; addr_b = 4'd7; din_b = 32'h00BBBB00;
        step();
        chk("coll dut0", 32'(coll_o[0]), 32'd1);
        chk("coll dut1", 32'(coll_o[1]), 32'd1);
        idle(); en_a = 1'b1; addr_a = 4'd7;
        step(); idle(); step(); step();
        chk("coll merged word", dout_a_o[1], 32'hA5BBAAAA);

        en_a = 1'b1; we_a = 4'hF; addr_a = 4'd13; din_a = 32'h12345678;
        en_b = 1'b1; we_b = 4'hF; addr_b = 4'd13; din_b = 32'h9ABCDEF0;
        step();
        idle(); en_a = 1'b1; addr_a = 4'd13;
        step(); idle(); step(); step();
        chk("oor dut1 dout_a", dout_a_o[1], 32'h0);
        chk("oor dut0 dout_a", dout_a_o[0], 32'h12345678);
        read_all();

        for (int n = 0; n < 300; n++) begin
            en_a = 1'($urandom_range(0, 3) != 0); en_b = 1'($urandom_range(0, 3) != 0);
            we_a = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            we_b = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            addr_a = 4'($urandom); addr_b = ($urandom_range(0, 3) == 0) ? addr_a : 4'($urandom);
            din_a = $urandom; din_b = $urandom;
            clr = 1'($urandom_range(0, 49) == 0);
            step();
        end
        idle();
        for (int k = 0; k < 40 && (busy_o[0] || busy_o[1]); k++) step();
        read_all();

        clr = 1'b1;
        step();
        idle();
        for (int k = 0; k < 4; k++) step();
        en_a = 1'b1; we_a = 4'hF; addr_a = 4'd2; din_a = 32'hCAFEF00D;
        step();
        chk("midscrub vld_a dut0", 32'(vld_a_o[0]), 32'd0);
        idle(); step(); step();
        rst_n = 1'b0;
        #1;
        chk("async reset busy dut0", 32'(busy_o[0]), 32'd1);
        chk("async reset vld_b dut1", 32'(vld_b_o[1]), 32'd0);
        step();
        rst_n = 1'b1;
        scrub_span("restart");
        read_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
